dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller between the MEM stage and the data memory port. It is the producer of `DC_stall`: it holds the pipeline through the hazard unit while a read miss is filled or a store is written through, and releases it in the same cycle the memory completes. One word per line; the memory side uses a simple req/ready handshake.

## Interface
- `bit_size`, 32: data and address width.
- `INDEX_BITS`, 4: line index width; the cache holds 2^INDEX_BITS lines.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `DC_read` in 1: load request from MEM stage.
- `DC_write` in 1: store request from MEM stage.
- `DC_addr` in bit_size: byte address; bits [1:0] ignored.
- `DC_in` in bit_size: store data.
- `DC_out` out bit_size: load data.
- `DC_stall` out 1: pipeline hold, combinational.
- `mem_req` out 1: memory request, registered.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr` out bit_size: word-aligned memory address.
- `mem_wdata` out bit_size: write data.
- `mem_rdata` in bit_size: read data, valid with `mem_ready`.
- `mem_ready` in 1: one-cycle completion pulse for the outstanding request.

## Operation
- Address split: index = `DC_addr[INDEX_BITS+1:2]`, tag = `DC_addr[bit_size-1:INDEX_BITS+2]`. Each line stores valid, tag and data.
- FSM states are IDLE, FILL and WTHRU.
- IDLE behaviour:
  - Read hit: `DC_out` = line data, `DC_stall` = 0.
  - Read miss: `DC_stall` = 1. At the edge, latch the address, set `mem_req`=1 and `mem_we`=0, then go to FILL.
  - Write (hit or miss): `DC_stall` = 1. At the edge, latch the address and data, set `mem_req`=1 and `mem_we`=1, then go to WTHRU.
  - If `DC_read` and `DC_write` are both high, treat the access as a write.
- FILL behaviour:
  - `DC_stall` = `!mem_ready`.
  - On `mem_ready`, `DC_out` = `mem_rdata` (bypass).
  - At that edge, write the line (valid=1, tag, data), drop `mem_req` and return to IDLE.
- WTHRU behaviour:
  - `DC_stall` = `!mem_ready`.
  - At the `mem_ready` edge, drop `mem_req` and return to IDLE.
  - If the tag matched at capture, update the line data at this edge. A miss does not allocate.
- `mem_addr`, `mem_wdata` and `mem_we` are stable for the whole time `mem_req` is high.
- `DC_out` is 0 when no read is in progress.

## Timing
- Reset values: state IDLE, all valid bits 0, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `DC_out` 0, `DC_stall` 0.
- Read hit: 0 stall cycles, data returned in the same cycle.
- Miss or store with `mem_ready` arriving N cycles after `mem_req` rises (N ≥ 1): `DC_stall` is high for exactly N cycles (the IDLE request cycle plus N-1 wait cycles) and falls in the `mem_ready` cycle, so the pipeline advances at that edge.
- `mem_ready` while in IDLE is ignored.
- Accesses issued back to back: a new request can be captured in the cycle immediately after returning to IDLE.
- Reset mid-transaction: return to IDLE, invalidate all lines and drop `mem_req` immediately (asynchronously). A `mem_ready` arriving afterwards is ignored.

## Configuration
- Macro `DC_PERF_CNT_EN`.
- When defined, adds two outputs, `DC_hit_cnt` and `DC_miss_cnt` (32 bits each, reset 0, wrap at 2^32):
  - `DC_hit_cnt` increments on each read hit accepted in IDLE.
  - `DC_miss_cnt` increments on each read miss captured.
  - Writes are not counted.
- When undefined, neither port nor the counter logic exists; all other behaviour is identical.

## Test plan
- After reset, read 0x0000_0040 with `mem_ready` 3 cycles after `mem_req` rises, `mem_rdata`=0xDEADBEEF → `DC_stall` high for 3 cycles and `DC_out`=0xDEADBEEF in the ready cycle. A repeat read gives a hit with 0 stall cycles and the same data.
- Write 0x12345678 to 0x40 (hit), ready after 2 cycles → `mem_we`=1, `mem_addr`=0x40, stall for 2 cycles. A subsequent read of 0x40 hits and returns 0x12345678.
- Write to 0x80 (miss) then read 0x80 → no allocation, so the read misses and issues `mem_req` with `mem_we`=0.
- Conflict: fill 0x40, then read 0x440 (same index, different tag) → miss and refill. A read of 0x40 then misses again.
- Assert `rst` during FILL → `mem_req` drops immediately. A late `mem_ready` has no effect, and a read of 0x40 then misses.
- With `DC_PERF_CNT_EN`: sequence miss, hit, hit, write → `DC_hit_cnt`=2, `DC_miss_cnt`=1.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl_if
// Description : Pipeline-side and memory-side signal bundle for dcache_ctrl.
//               Counter outputs exist only when DC_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_ctrl_if #(
    parameter int bit_size = 32
);
    logic                DC_read;
    logic                DC_write;
    logic [bit_size-1:0] DC_addr;
    logic [bit_size-1:0] DC_in;
    logic [bit_size-1:0] DC_out;
    logic                DC_stall;
    logic                mem_req;
    logic                mem_we;
    logic [bit_size-1:0] mem_addr;
    logic [bit_size-1:0] mem_wdata;
    logic [bit_size-1:0] mem_rdata;
    logic                mem_ready;
`ifdef DC_PERF_CNT_EN
    logic [31:0]         DC_hit_cnt;
    logic [31:0]         DC_miss_cnt;
`endif

    modport slave (
        input  DC_read, DC_write, DC_addr, DC_in, mem_rdata, mem_ready,
        output DC_out, DC_stall, mem_req, mem_we, mem_addr, mem_wdata
`ifdef DC_PERF_CNT_EN
        , output DC_hit_cnt, DC_miss_cnt
`endif
    );

    modport master (
        output DC_read, DC_write, DC_addr, DC_in, mem_rdata, mem_ready,
        input  DC_out, DC_stall, mem_req, mem_we, mem_addr, mem_wdata
`ifdef DC_PERF_CNT_EN
        , input DC_hit_cnt, DC_miss_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped, write-through, no-write-allocate data cache
//               controller, one word per line. Optional macro DC_PERF_CNT_EN
//               adds read hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int bit_size   = 32,
    parameter int INDEX_BITS = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    dcache_ctrl_if.slave      bus
);
    localparam int c_LINES    = 1 << INDEX_BITS;
    localparam int c_TAG_BITS = bit_size - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WTHRU = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_LINES-1:0]      r_valid;
    logic [c_TAG_BITS-1:0]   r_tag  [c_LINES];
    logic [bit_size-1:0]     r_data [c_LINES];
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [bit_size-1:0]     r_mem_addr;
    logic [bit_size-1:0]     r_mem_wdata;
    logic                    r_wr_hit;

    logic [INDEX_BITS-1:0]   w_idx;
    logic [c_TAG_BITS-1:0]   w_tag;
    logic                    w_hit;
    logic [bit_size-1:0]     w_word_addr;
    logic [INDEX_BITS-1:0]   w_fill_idx;
    logic [c_TAG_BITS-1:0]   w_fill_tag;
    logic [bit_size-1:0]     w_dc_out;
    logic                    w_dc_stall;
    logic                    w_unused;

    assign w_idx       = bus.DC_addr[INDEX_BITS+1:2];
    assign w_tag       = bus.DC_addr[bit_size-1:INDEX_BITS+2];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_word_addr = {bus.DC_addr[bit_size-1:2], 2'b00};
    // The latched request address is the single source of the line being
    // filled or written through; the pipeline address may change afterwards.
    assign w_fill_idx  = r_mem_addr[INDEX_BITS+1:2];
    assign w_fill_tag  = r_mem_addr[bit_size-1:INDEX_BITS+2];
    assign w_unused    = &{1'b0, bus.DC_addr[1:0]};

    always_comb begin
        w_dc_out   = '0;
        w_dc_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.DC_write) begin
                    w_dc_stall = 1'b1;
                end else if (bus.DC_read) begin
                    if (w_hit) begin
                        w_dc_out = r_data[w_idx];
                    end else begin
                        w_dc_stall = 1'b1;
                    end
                end
            end
            S_FILL: begin
                w_dc_stall = !bus.mem_ready;
                if (bus.mem_ready) begin
                    w_dc_out = bus.mem_rdata;
                end
            end
            S_WTHRU: begin
                w_dc_stall = !bus.mem_ready;
            end
            default: begin
                w_dc_stall = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wr_hit    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.DC_write) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_word_addr;
                        r_mem_wdata <= bus.DC_in;
                        r_wr_hit    <= w_hit;
                        r_state     <= S_WTHRU;
                    end else if (bus.DC_read && !w_hit) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= w_word_addr;
                        r_state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (bus.mem_ready) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        r_mem_req           <= 1'b0;
                        r_state             <= S_IDLE;
                    end
                end
                S_WTHRU: begin
                    if (bus.mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and data storage need no reset: validity is governed by r_valid.
    always_ff @(posedge clk) begin
        if (r_state == S_FILL && bus.mem_ready) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= bus.mem_rdata;
        end else if (r_state == S_WTHRU && bus.mem_ready && r_wr_hit) begin
            r_data[w_fill_idx] <= r_mem_wdata;
        end
    end

    assign bus.DC_out    = w_dc_out;
    assign bus.DC_stall  = w_dc_stall;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

`ifdef DC_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_IDLE && bus.DC_read && !bus.DC_write) begin
            if (w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign bus.DC_hit_cnt  = r_hit_cnt;
    assign bus.DC_miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Directed self-checking bench for dcache_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    dcache_ctrl_if #(.bit_size(32)) bus ();

    dcache_ctrl #(.bit_size(32), .INDEX_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observed results of the last access
    int          st;
    logic        rq, we, un;
    logic [31:0] ad, wd, ou;

    task automatic set_idle();
        bus.DC_read   = 1'b0;
        bus.DC_write  = 1'b0;
        bus.DC_addr   = '0;
        bus.DC_in     = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        set_idle();
    endtask

    // One pipeline access with a memory model answering n cycles after mem_req
    // rises. Inputs are left applied so that a following call is back to back.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int n, input logic [31:0] rdata);
        int  req_cnt;
        logic done;
        st = 0; rq = 1'b0; we = 1'b0; ad = '0; wd = '0; ou = '0; un = 1'b0;
        req_cnt = 0; done = 1'b0;
        @(negedge clk);
        bus.DC_read   = rd;
        bus.DC_write  = wr;
        bus.DC_addr   = addr;
        bus.DC_in     = wdata;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (c != 0) begin
                @(negedge clk);
                bus.mem_ready = 1'b0;
            end
            if (bus.mem_req) begin
                if (rq && (bus.mem_we !== we || bus.mem_addr !== ad || bus.mem_wdata !== wd))
                    un = 1'b1;
                if (!rq) begin
                    we = bus.mem_we; ad = bus.mem_addr; wd = bus.mem_wdata;
                end
                rq = 1'b1;
                req_cnt++;
                if (req_cnt == n) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = rdata;
                end
            end
            #2;
            if (bus.DC_stall) begin
                st++;
            end else begin
                ou = bus.DC_out;
                done = 1'b1;
            end
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL access_timeout addr=%h: got no completion in 64 cycles, required completion", addr);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        #2;
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %b required 0", bus.mem_req); end
        n_vec++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b required 0", bus.mem_we); end
        n_vec++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h required 0", bus.mem_addr); end
        n_vec++; if (bus.mem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_mem_wdata: got %h required 0", bus.mem_wdata); end
        n_vec++; if (bus.DC_out !== 32'h0) begin n_err++; $display("FAIL rst_dc_out: got %h required 0", bus.DC_out); end
        n_vec++; if (bus.DC_stall !== 1'b0) begin n_err++; $display("FAIL rst_dc_stall: got %b required 0", bus.DC_stall); end
`ifdef DC_PERF_CNT_EN
        n_vec++; if (bus.DC_hit_cnt !== 32'h0) begin n_err++; $display("FAIL rst_hit_cnt: got %0d required 0", bus.DC_hit_cnt); end
        n_vec++; if (bus.DC_miss_cnt !== 32'h0) begin n_err++; $display("FAIL rst_miss_cnt: got %0d required 0", bus.DC_miss_cnt); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read_miss_fill();
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF);
        n_vec++; if (st !== 3) begin n_err++; $display("FAIL fill_stall: got %0d required 3", st); end
        n_vec++; if (ou !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL fill_bypass: got %h required deadbeef", ou); end
        n_vec++; if (rq !== 1'b1 || we !== 1'b0) begin n_err++; $display("FAIL fill_req: got req=%b we=%b required req=1 we=0", rq, we); end
        n_vec++; if (ad !== 32'h40) begin n_err++; $display("FAIL fill_addr: got %h required 00000040", ad); end
        n_vec++; if (un !== 1'b0) begin n_err++; $display("FAIL fill_stable: got unstable=%b required 0", un); end
        idle_cycle();
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0);
        n_vec++; if (st !== 0 || rq !== 1'b0) begin n_err++; $display("FAIL hit_stall: got stall=%0d req=%b required 0/0", st, rq); end
        n_vec++; if (ou !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL hit_data: got %h required deadbeef", ou); end
        idle_cycle();
        #2;
        n_vec++; if (bus.DC_out !== 32'h0) begin n_err++; $display("FAIL idle_out: got %h required 0", bus.DC_out); end
    endtask

    task automatic test_write_hit();
        access(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 2, 32'h0);
        n_vec++; if (st !== 2) begin n_err++; $display("FAIL wr_stall: got %0d required 2", st); end
        n_vec++; if (we !== 1'b1 || ad !== 32'h40) begin n_err++; $display("FAIL wr_req: got we=%b addr=%h required we=1 addr=00000040", we, ad); end
        n_vec++; if (wd !== 32'h1234_5678 || un !== 1'b0) begin n_err++; $display("FAIL wr_data: got %h unstable=%b required 12345678/0", wd, un); end
        idle_cycle();
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0);
        n_vec++; if (st !== 0 || ou !== 32'h1234_5678) begin n_err++; $display("FAIL wr_hit_read: got stall=%0d data=%h required 0/12345678", st, ou); end
        // simultaneous read and write behaves as a write
        access(1'b1, 1'b1, 32'h0000_0043, 32'h0000_0055, 1, 32'hFFFF_FFFF);
        n_vec++; if (we !== 1'b1 || ad !== 32'h40 || st !== 1) begin n_err++; $display("FAIL rdwr_as_write: got we=%b addr=%h stall=%0d required 1/00000040/1", we, ad, st); end
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0);
        n_vec++; if (st !== 0 || ou !== 32'h0000_0055) begin n_err++; $display("FAIL rdwr_read: got stall=%0d data=%h required 0/00000055", st, ou); end
        idle_cycle();
    endtask

    task automatic test_write_miss_no_alloc();
        access(1'b0, 1'b1, 32'h0000_0080, 32'hAAAA_5555, 1, 32'h0);
        n_vec++; if (st !== 1 || we !== 1'b1 || ad !== 32'h80) begin n_err++; $display("FAIL wmiss_req: got stall=%0d we=%b addr=%h required 1/1/00000080", st, we, ad); end
        idle_cycle();
        access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 2, 32'h0BAD_F00D);
        n_vec++; if (rq !== 1'b1 || we !== 1'b0 || st !== 2) begin n_err++; $display("FAIL wmiss_read: got req=%b we=%b stall=%0d required 1/0/2", rq, we, st); end
        n_vec++; if (ou !== 32'h0BAD_F00D) begin n_err++; $display("FAIL wmiss_data: got %h required 0badf00d", ou); end
        idle_cycle();
    endtask

    task automatic test_conflict();
        access(1'b1, 1'b0, 32'h0000_0440, 32'h0, 1, 32'h1111_2222);
        n_vec++; if (rq !== 1'b1 || ad !== 32'h440 || st !== 1) begin n_err++; $display("FAIL conf_miss: got req=%b addr=%h stall=%0d required 1/00000440/1", rq, ad, st); end
        n_vec++; if (ou !== 32'h1111_2222) begin n_err++; $display("FAIL conf_data: got %h required 11112222", ou); end
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h1234_5678);
        n_vec++; if (rq !== 1'b1 || ad !== 32'h40) begin n_err++; $display("FAIL conf_evict: got req=%b addr=%h required 1/00000040", rq, ad); end
        n_vec++; if (ou !== 32'h1234_5678) begin n_err++; $display("FAIL conf_refill: got %h required 12345678", ou); end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 32'hCAFE_F00D);
        access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 32'h0);
        n_vec++; if (st !== 0 || rq !== 1'b0 || ou !== 32'hCAFE_F00D) begin n_err++; $display("FAIL b2b_fill_hit: got stall=%0d req=%b data=%h required 0/0/cafef00d", st, rq, ou); end
        access(1'b0, 1'b1, 32'h0000_0100, 32'h0000_0001, 1, 32'h0);
        access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 32'h0);
        n_vec++; if (st !== 0 || ou !== 32'h0000_0001) begin n_err++; $display("FAIL b2b_write_hit: got stall=%0d data=%h required 0/00000001", st, ou); end
        access(1'b0, 1'b1, 32'h0000_0044, 32'h0000_0099, 3, 32'h0);
        n_vec++; if (st !== 3 || ad !== 32'h44) begin n_err++; $display("FAIL b2b_write: got stall=%0d addr=%h required 3/00000044", st, ad); end
        idle_cycle();
    endtask

    task automatic test_idle_ready();
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5A5A_5A5A;
        #2;
        n_vec++; if (bus.DC_stall !== 1'b0 || bus.DC_out !== 32'h0) begin n_err++; $display("FAIL idle_ready_out: got stall=%b out=%h required 0/0", bus.DC_stall, bus.DC_out); end
        idle_cycle();
        #2;
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL idle_ready_req: got %b required 0", bus.mem_req); end
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        @(negedge clk);
        bus.DC_read = 1'b1;
        bus.DC_addr = 32'h0000_0040;
        @(negedge clk);
        n_vec++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL mid_req_up: got %b required 1", bus.mem_req); end
        #2;
        rst = 1'b1;
        bus.DC_read = 1'b0;
        #1;
        n_vec++; if (bus.mem_req !== 1'b0 || bus.DC_stall !== 1'b0) begin n_err++; $display("FAIL mid_async_drop: got req=%b stall=%b required 0/0", bus.mem_req, bus.DC_stall); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        #2;
        n_vec++; if (bus.DC_out !== 32'h0 || bus.DC_stall !== 1'b0) begin n_err++; $display("FAIL mid_late_ready: got out=%h stall=%b required 0/0", bus.DC_out, bus.DC_stall); end
        idle_cycle();
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h3333_4444);
        n_vec++; if (rq !== 1'b1 || st !== 1 || ou !== 32'h3333_4444) begin n_err++; $display("FAIL mid_invalidated: got req=%b stall=%0d data=%h required 1/1/33334444", rq, st, ou); end
        idle_cycle();
    endtask

`ifdef DC_PERF_CNT_EN
    task automatic test_perf_cnt();
        do_reset();
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 2, 32'h0000_00AB);
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0);
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0);
        access(1'b0, 1'b1, 32'h0000_0040, 32'h0000_00CD, 1, 32'h0);
        idle_cycle();
        #2;
        n_vec++; if (bus.DC_hit_cnt !== 32'd2) begin n_err++; $display("FAIL perf_hit: got %0d required 2", bus.DC_hit_cnt); end
        n_vec++; if (bus.DC_miss_cnt !== 32'd1) begin n_err++; $display("FAIL perf_miss: got %0d required 1", bus.DC_miss_cnt); end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        set_idle();
        test_reset();
        test_read_miss_fill();
        test_write_hit();
        test_write_miss_no_alloc();
        test_conflict();
        test_back_to_back();
        test_idle_ready();
        test_reset_mid_fill();
`ifdef DC_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
